block_dp_arbiter: RTL

- Shares one instance of the two-flop NAND datapath (`block` cell: `in1`/`in2`/`in3` in, `out1` out) between NUM_REQ requesters.
- Round-robin arbitration issues one 1-bit operation per cycle and drives the datapath inputs.
- Tracks in-flight operations through the fixed datapath latency, captures `out1`, and returns tagged results through a small response FIFO with credit-based backpressure.
- Sits between the requester logic and the `block` datapath.

---
 rtl/block_dp_pkg.sv | 18 +
 rtl/block_dp_rsp_fifo.sv | 67 ++++++
 rtl/block_dp_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/block_dp_pkg.sv
// Shared FSM type, id-width helper and default sizing for the block datapath arbiter.
package block_dp_pkg;

    localparam int unsigned DEF_LATENCY    = 2;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } dp_state_e;

    // A single requester still needs a 1-bit id field.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/block_dp_rsp_fifo.sv
// Synchronous response FIFO holding {id, data}; pointers wrap modulo DEPTH (any depth).
module block_dp_rsp_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ID_W  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [ID_W-1:0]              push_id,
    input  logic                         push_data,
    input  logic                         pop,
    output logic [ID_W-1:0]              head_id,
    output logic                         head_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [ID_W-1:0] id_mem [DEPTH];
    logic [DEPTH-1:0] data_mem;
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [CW-1:0]   cnt_q;
    logic            do_push;
    logic            do_pop;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign do_pop  = pop && !empty;
    // A pop frees the head slot, so a push into a full FIFO is legal in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wrap_inc(wr_q);
            if (do_pop)  rd_q <= wrap_inc(rd_q);
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            id_mem[wr_q]   <= push_id;
            data_mem[wr_q] <= push_data;
        end
    end

    assign head_id   = empty ? '0 : id_mem[rd_q];
    assign head_data = !empty && data_mem[rd_q];

endmodule

// File: rtl/block_dp_arbiter.sv
// Round-robin sharing of one block datapath among NUM_REQ requesters with tagged, in-order
// responses. Optional grant statistics are compiled in with BLOCK_DP_ARBITER_STATS_EN.
module block_dp_arbiter
    import block_dp_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned LATENCY    = DEF_LATENCY,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [2*NUM_REQ-1:0]            req_data,
    input  logic [NUM_REQ-1:0]              req_sel,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            flush,
    output logic                            dp_in1,
    output logic                            dp_in2,
    output logic                            dp_in3,
    input  logic                            dp_out1,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [id_width(NUM_REQ)-1:0]    rsp_id,
    output logic                            rsp_data,
    output logic                            busy
`ifdef BLOCK_DP_ARBITER_STATS_EN
    ,
    input  logic                            stats_clr,
    output logic [NUM_REQ*16-1:0]           grant_cnt
`endif
);

    localparam int unsigned ID_W  = id_width(NUM_REQ);
    localparam int unsigned SUM_W = ID_W + 1;
    localparam int unsigned CR_W  = $clog2(FIFO_DEPTH + 1);

    dp_state_e       state_q;
    logic [ID_W-1:0] ptr_q;
    logic [CR_W-1:0] credits_q;
    logic [LATENCY:0] pipe_vld_q;
    logic [ID_W-1:0] pipe_id_q [LATENCY+1];

    logic            grant_en;
    logic            found;
    logic [ID_W-1:0] winner;
    logic [SUM_W-1:0] slot;
    logic            issue;
    logic            pop;
    logic            pipe_empty;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CR_W-1:0] fifo_count;

    assign grant_en   = (state_q == StRun) && (credits_q != '0) && !flush;
    assign issue      = |(req_valid & req_ready);
    assign pop        = rsp_valid && rsp_ready;
    assign pipe_empty = ~|pipe_vld_q;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin
        req_ready = '0;
        found     = 1'b0;
        winner    = '0;
        slot      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            slot = SUM_W'(ptr_q) + SUM_W'(k);
            if (slot >= SUM_W'(NUM_REQ)) slot = slot - SUM_W'(NUM_REQ);
            if (!found && req_valid[slot[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = slot[ID_W-1:0];
            end
        end
        if (grant_en && found) req_ready[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|req_valid && !flush) state_q <= StRun;
                end
                StRun: begin
                    if (flush) begin
                        state_q <= StDrain;
                    end else if (!(|req_valid) && pipe_empty) begin
                        state_q <= StIdle;
                    end
                end
                StDrain: begin
                    if (pipe_empty && !flush) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            credits_q <= CR_W'(FIFO_DEPTH);
            dp_in1    <= 1'b0;
            dp_in2    <= 1'b0;
            dp_in3    <= 1'b0;
        end else begin
            if (issue) begin
                ptr_q  <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                dp_in1 <= req_data[{winner, 1'b1}];
                dp_in2 <= req_data[{winner, 1'b0}];
                dp_in3 <= req_sel[winner];
            end
            // Credits = free FIFO slots minus ops still travelling through the datapath.
            case ({issue, pop})
                2'b10:   credits_q <= credits_q - 1'b1;
                2'b01:   credits_q <= credits_q + 1'b1;
                default: credits_q <= credits_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int unsigned i = 0; i <= LATENCY; i++) pipe_id_q[i] <= '0;
        end else begin
            pipe_vld_q   <= {pipe_vld_q[LATENCY-1:0], issue};
            pipe_id_q[0] <= winner;
            for (int unsigned i = 1; i <= LATENCY; i++) pipe_id_q[i] <= pipe_id_q[i-1];
        end
    end

    // The last tracking stage lines up with dp_out1 for the op that owns it.
    block_dp_rsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .ID_W  (ID_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pipe_vld_q[LATENCY]),
        .push_id   (pipe_id_q[LATENCY]),
        .push_data (dp_out1),
        .pop       (pop),
        .head_id   (rsp_id),
        .head_data (rsp_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign busy      = !pipe_empty || (fifo_count != '0);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_full && pipe_vld_q[LATENCY] && !pop));

`ifdef BLOCK_DP_ARBITER_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (stats_clr) begin
                    cnt_q[i] <= '0;
                end else if (req_valid[i] && req_ready[i] && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) grant_cnt[16*i +: 16] = cnt_q[i];
    end
`endif

endmodule
